ex_stage: RTL

- Execute stage; sits directly downstream of the ID/EX pipeline register and feeds the EX/MEM register.
- Single-cycle ALU for logic, shift and add/sub/compare ops.
- Iterative radix-2 divider (signed/unsigned quotient and remainder) that stalls the front of the pipeline while busy.
- Produces the write-back triple (waddr, we, wdata) plus a stall request to pipeline control.

---
 rtl/ex_stage_if.sv | 33 +++
 rtl/ex_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_if
// Brief    : ID/EX operand bus into the execute stage and EX/MEM write-back bus.
// Revision : 1.0
// ============================================================================
interface ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              flush;
  logic [7:0]        ex_aluop;
  logic [2:0]        ex_alusel;
  logic [DATA_W-1:0] ex_rdata1;
  logic [DATA_W-1:0] ex_rdata2;
  logic [ADDR_W-1:0] ex_waddr;
  logic              ex_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic              stall_req;

  modport master (
    output flush, ex_aluop, ex_alusel, ex_rdata1, ex_rdata2, ex_waddr, ex_we,
    input  mem_waddr, mem_we, mem_wdata, stall_req
  );

  modport slave (
    input  flush, ex_aluop, ex_alusel, ex_rdata1, ex_rdata2, ex_waddr, ex_we,
    output mem_waddr, mem_we, mem_wdata, stall_req
  );
endinterface
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : Execute stage: single-cycle ALU plus iterative restoring divider.
// Revision : 1.0
// ============================================================================
module ex_stage #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DIV_CYCLES = 32
) (
  input  wire logic  clk,
  input  wire logic  rst,
  ex_stage_if.slave  bus
);

  localparam logic [2:0] c_sel_logic = 3'b001;
  localparam logic [2:0] c_sel_shift = 3'b010;
  localparam logic [2:0] c_sel_arith = 3'b011;
  localparam logic [2:0] c_sel_div   = 3'b100;
  localparam logic [5:0] c_cnt_last  = 6'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state, w_next;
  logic [5:0]        r_cnt;
  logic [DATA_W-1:0] r_quot, r_rem, r_div;
  logic              r_neg_q, r_neg_r;

  logic [DATA_W-1:0] w_a, w_b, w_alu, w_abs_a, w_abs_b, w_q_out, w_r_out;
  logic [DATA_W:0]   w_shift_rem, w_trial;
  logic [4:0]        w_shamt;
  logic              w_is_div_op, w_signed, w_want_rem, w_a_neg, w_b_neg, w_class_ok;
  logic              w_start, w_we, w_stall;
  logic [DATA_W-1:0] w_wdata;

  assign w_a     = bus.ex_rdata1;
  assign w_b     = bus.ex_rdata2;
  assign w_shamt = w_b[4:0];

  assign w_is_div_op = (bus.ex_alusel == c_sel_div) &&
                       (bus.ex_aluop inside {8'h1A, 8'h1B, 8'h1C, 8'h1D});
  assign w_signed    = (bus.ex_aluop == 8'h1A) || (bus.ex_aluop == 8'h1C);
  assign w_want_rem  = (bus.ex_aluop == 8'h1C) || (bus.ex_aluop == 8'h1D);
  assign w_class_ok  = (bus.ex_alusel inside {c_sel_logic, c_sel_shift, c_sel_arith, c_sel_div});
  assign w_a_neg     = w_signed & w_a[DATA_W-1];
  assign w_b_neg     = w_signed & w_b[DATA_W-1];
  assign w_abs_a     = w_a_neg ? -w_a : w_a;
  assign w_abs_b     = w_b_neg ? -w_b : w_b;

  // Restoring step: shift in next dividend bit, keep the difference if it did not borrow.
  assign w_shift_rem = {r_rem, r_quot[DATA_W-1]};
  assign w_trial     = w_shift_rem - {1'b0, r_div};

  assign w_q_out = r_neg_q ? -r_quot : r_quot;
  assign w_r_out = r_neg_r ? -r_rem  : r_rem;

  always_comb begin
    w_alu = '0;
    case (bus.ex_alusel)
      c_sel_logic: begin
        case (bus.ex_aluop)
          8'h24:   w_alu = w_a & w_b;
          8'h25:   w_alu = w_a | w_b;
          8'h26:   w_alu = w_a ^ w_b;
          8'h27:   w_alu = ~(w_a | w_b);
          default: w_alu = '0;
        endcase
      end
      c_sel_shift: begin
        case (bus.ex_aluop)
          8'h00:   w_alu = w_a << w_shamt;
          8'h02:   w_alu = w_a >> w_shamt;
          8'h03:   w_alu = $unsigned($signed(w_a) >>> w_shamt);
          default: w_alu = '0;
        endcase
      end
      c_sel_arith: begin
        case (bus.ex_aluop)
          8'h20:   w_alu = w_a + w_b;
          8'h22:   w_alu = w_a - w_b;
          8'h2A:   w_alu = {{(DATA_W-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
          8'h2B:   w_alu = {{(DATA_W-1){1'b0}}, (w_a < w_b)};
          default: w_alu = '0;
        endcase
      end
      default: w_alu = '0;
    endcase
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_stall = 1'b0;
    w_we    = 1'b0;
    w_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (w_is_div_op) begin
          w_start = 1'b1;
          w_stall = 1'b1;
          w_next  = (w_b == '0) ? S_DONE : S_BUSY;
        end else begin
          w_we    = w_class_ok ? bus.ex_we : 1'b0;
          w_wdata = w_alu;
        end
      end
      S_BUSY: begin
        w_stall = 1'b1;
        if (r_cnt == c_cnt_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_we    = bus.ex_we;
        w_wdata = w_want_rem ? w_r_out : w_q_out;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (bus.flush) begin
      w_next  = S_IDLE;
      w_start = 1'b0;
      w_stall = 1'b0;
      w_we    = 1'b0;
      w_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_cnt <= '0;
        // Zero divisor: all-ones quotient and raw dividend as remainder, no sign fix-up.
        if (w_b == '0) begin
          r_quot  <= '1;
          r_rem   <= w_a;
          r_div   <= '0;
          r_neg_q <= 1'b0;
          r_neg_r <= 1'b0;
        end else begin
          r_quot  <= w_abs_a;
          r_rem   <= '0;
          r_div   <= w_abs_b;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
        end
      end else if (r_state == S_BUSY && !bus.flush) begin
        r_cnt <= r_cnt + 6'd1;
        if (!w_trial[DATA_W]) begin
          r_rem  <= w_trial[DATA_W-1:0];
          r_quot <= {r_quot[DATA_W-2:0], 1'b1};
        end else begin
          r_rem  <= w_shift_rem[DATA_W-1:0];
          r_quot <= {r_quot[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  assign bus.mem_waddr = bus.ex_waddr;
  assign bus.mem_we    = w_we;
  assign bus.mem_wdata = w_wdata;
  assign bus.stall_req = w_stall;

endmodule
`default_nettype wire
